// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the forwarding / hazard controller.
// Register_Bank and the decoder import this package too, so the opcode values,
// instruction field positions and operand-select encoding are defined only here.
package fwd_hazard_ctrl_pkg;

   // Instruction word layout
   localparam int INS_W  = 24;
   localparam int OP_HI  = 23;
   localparam int OP_LO  = 18;
   localparam int RD_HI  = 17;
   localparam int RD_LO  = 13;
   localparam int RS1_HI = 12;
   localparam int RS1_LO = 8;
   localparam int RS2_HI = 7;
   localparam int RS2_LO = 3;
   localparam int REG_W  = 5;

   // Opcodes; every value not listed here behaves as a NOP
   localparam logic [5:0] OP_ALU_R = 6'h01;
   localparam logic [5:0] OP_ALU_I = 6'h02;
   localparam logic [5:0] OP_LOAD  = 6'h03;
   localparam logic [5:0] OP_STORE = 6'h04;

   // Operand source select seen by Register_Bank
   typedef enum logic [1:0] {
      SEL_REG = 2'b00,
      SEL_EX  = 2'b01,
      SEL_DM  = 2'b10,
      SEL_WB  = 2'b11
   } sel_t;

   // One entry of the destination-tracking pipe
   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             is_load;
   } stage_t;

   // What an opcode class reads, writes and whether it carries an immediate
   typedef struct packed {
      logic reads_rs1;
      logic reads_rs2;
      logic writes_rd;
      logic uses_imm;
      logic is_load;
   } op_class_t;

   // Map an opcode onto its operand usage
   function automatic op_class_t classify(input logic [5:0] op);
      op_class_t c;
      c = '0;
      case (op)
         OP_ALU_R: begin
            c.reads_rs1 = 1'b1;
            c.reads_rs2 = 1'b1;
            c.writes_rd = 1'b1;
         end
         OP_ALU_I: begin
            c.reads_rs1 = 1'b1;
            c.writes_rd = 1'b1;
            c.uses_imm  = 1'b1;
         end
         OP_LOAD: begin
            c.reads_rs1 = 1'b1;
            c.writes_rd = 1'b1;
            c.uses_imm  = 1'b1;
            c.is_load   = 1'b1;
         end
         OP_STORE: begin
            c.reads_rs1 = 1'b1;
            c.reads_rs2 = 1'b1;
            c.uses_imm  = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/fwd_match.sv
// Single-operand forwarding select: compares one source register against the
// EX, DM and WB destination entries and picks the youngest matching stage.
module fwd_match
   import fwd_hazard_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] rs,
   input  logic             rd_en,
   input  stage_t           ex,
   input  stage_t           dm,
   input  stage_t           wb,
   output logic [1:0]       sel
);

   // Load flags are only relevant to stall detection, not to source selection
   logic unused_load;
   assign unused_load = ex.is_load ^ dm.is_load ^ wb.is_load;

   // Youngest matching stage wins; r0 and unread operands always use the regfile
   always_comb begin
      sel = SEL_REG;
      if (rd_en && (rs != '0)) begin
         if (ex.valid && (ex.rd == rs)) begin
            sel = SEL_EX;
         end else if (dm.valid && (dm.rd == rs)) begin
            sel = SEL_DM;
         end else if (wb.valid && (wb.rd == rs)) begin
            sel = SEL_WB;
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the decode stage.
// Tracks destination registers through EX/DM/WB and produces operand source
// selects, the immediate select and a one-cycle stall for load-use pairs.
module fwd_hazard_ctrl
   import fwd_hazard_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [INS_W-1:0] ins,
   input  logic             ins_valid,
   output logic [1:0]       mux_sel_A,
   output logic [1:0]       mux_sel_B,
   output logic             imm_sel,
   output logic             stall,
   output logic [REG_W-1:0] RW_dm,
   output logic [REG_W-1:0] RW_wb,
   output logic             wb_we
);

   logic [5:0]       opcode;
   logic [REG_W-1:0] rd;
   logic [REG_W-1:0] rs1;
   logic [REG_W-1:0] rs2;
   logic             unused_bits;
   op_class_t        cls;
   logic             active;
   logic             load_use;
   logic             rd_en_a;
   logic             rd_en_b;
   stage_t           ex_q;
   stage_t           dm_q;
   stage_t           wb_q;
   stage_t           ex_next;

   assign opcode      = ins[OP_HI:OP_LO];
   assign rd          = ins[RD_HI:RD_LO];
   assign rs1         = ins[RS1_HI:RS1_LO];
   assign rs2         = ins[RS2_HI:RS2_LO];
   assign unused_bits = ^ins[RS2_LO-1:0];
   assign cls         = classify(opcode);

   // Reset masks the instruction so every output is quiet while rst is high
   assign active = ins_valid & ~rst;

   // A load still in EX cannot forward yet; any real read of its target waits a cycle
   always_comb begin
      load_use = 1'b0;
      if (active && ex_q.valid && ex_q.is_load) begin
         if (cls.reads_rs1 && (rs1 != '0) && (ex_q.rd == rs1)) begin
            load_use = 1'b1;
         end
         if (cls.reads_rs2 && (rs2 != '0) && (ex_q.rd == rs2)) begin
            load_use = 1'b1;
         end
      end
   end

   assign stall   = load_use;
   assign imm_sel = active & cls.uses_imm;

   // Selects are held at the regfile while stalling; the retry picks up the load from DM
   assign rd_en_a = active & ~load_use & cls.reads_rs1;
   assign rd_en_b = active & ~load_use & cls.reads_rs2;

   fwd_match u_match_a (
      .rs    (rs1),
      .rd_en (rd_en_a),
      .ex    (ex_q),
      .dm    (dm_q),
      .wb    (wb_q),
      .sel   (mux_sel_A)
   );

   fwd_match u_match_b (
      .rs    (rs2),
      .rd_en (rd_en_b),
      .ex    (ex_q),
      .dm    (dm_q),
      .wb    (wb_q),
      .sel   (mux_sel_B)
   );

   // Next EX entry: a bubble unless a real, non-stalled instruction writes a non-zero RD
   always_comb begin
      ex_next = '0;
      if (active && !load_use && cls.writes_rd && (rd != '0)) begin
         ex_next.valid   = 1'b1;
         ex_next.rd      = rd;
         ex_next.is_load = cls.is_load;
      end
   end

   // Destination tracking pipe, advancing every clock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q <= '0;
         dm_q <= '0;
         wb_q <= '0;
      end else begin
         ex_q <= ex_next;
         dm_q <= ex_q;
         wb_q <= dm_q;
      end
   end

   assign RW_dm = dm_q.valid ? dm_q.rd : '0;
   assign RW_wb = wb_q.valid ? wb_q.rd : '0;
   assign wb_we = wb_q.valid;

endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have port: ins  in  24  decode-stage instruction word; opcode [23:18], RD [17:13], RS1 [12:8], RS2 [7:3], [2:0] ignored.
REQ-003 SHALL have port: ins_valid  in  1  ins holds a real instruction this cycle.
REQ-004 SHALL have ports: mux_sel_A, mux_sel_B  out  2  Register_Bank operand source; 00 regfile, 01 ans_ex, 10 ans_dm, 11 ans_wb.
REQ-005 SHALL have port: imm_sel  out  1  Register_Bank B operand taken from imm.
REQ-006 SHALL have port: stall  out  1  upstream holds ins and PC this cycle.
REQ-007 SHALL have ports: RW_dm  out  5  DM-stage destination register; RW_wb  out  5  WB-stage destination register; wb_we  out  1  regfile write enable for RW_wb.

Function
REQ-008 Opcode classes SHALL be: 6'h01 ALU_R (reads RS1, RS2; writes RD), 6'h02 ALU_I (reads RS1; writes RD; imm), 6'h03 LOAD (reads RS1; writes RD; imm), 6'h04 STORE (reads RS1, RS2; no write; imm), all others NOP (no read, no write).
REQ-009 Destination tracking SHALL be a 3-stage registered pipe EX->DM->WB, each stage holding {valid, rd, is_load}; advances every clock.
REQ-010 EX stage SHALL load decode {ins_valid & writes & RD!=0, RD, opcode==LOAD}; loads a bubble (valid=0) when stall=1 or ins_valid=0.
REQ-011 mux_sel_A SHALL be combinational from the current ins: 01 if EX valid and EX.rd==RS1, else 10 if DM match, else 11 if WB match, else 00 (youngest stage wins).
REQ-012 mux_sel_B SHALL follow REQ-011 using RS2, and SHALL be 00 for ALU_I and LOAD.
REQ-013 RS==0 SHALL never forward (r0 is constant zero); select 00.
REQ-014 Operand not read by the opcode class SHALL give select 00.
REQ-015 imm_sel SHALL be 1 for ALU_I, LOAD, STORE with ins_valid=1, else 0.
REQ-016 stall SHALL be 1 when ins_valid, EX valid, EX.is_load, and EX.rd equals a source actually read by ins (RS!=0); exactly one cycle per load-use pair.
REQ-017 While stall=1, mux_sel_A, mux_sel_B SHALL be 00; next cycle the held ins sees the load in DM and selects 10.
REQ-018 RW_dm SHALL equal DM.rd when DM valid, else 0; RW_wb and wb_we SHALL reflect WB stage (wb_we=WB.valid).
REQ-019 ins_valid=0 SHALL force mux_sel 00, imm_sel 0, stall 0.
REQ-020 Latency: selects/stall combinational, same cycle as ins; tracking updated at the following rising edge.

Reset
REQ-021 rst=1 SHALL asynchronously clear all stage valid bits, rd fields and is_load bits.
REQ-022 During and after reset: mux_sel_A=mux_sel_B=00, imm_sel=0, stall=0, RW_dm=0, RW_wb=0, wb_we=0.
REQ-023 Reset asserted mid-stall SHALL drop stall immediately; first instruction after release sees no forwarding.

Structure
REQ-024 Opcode constants, field bit positions, and the 2-bit select encoding SHALL live in a shared package used also by Register_Bank and the decoder.
REQ-025 One sub-module, fwd_match, SHALL compute a single operand select from {RS, read-enable, three stage entries}; instantiated twice (A, B).

Verification
REQ-026 ALU_R r3<-r1,r2 (ins 24'h046110) then ALU_R r4<-r3,r3 -> second cycle mux_sel_A=01, mux_sel_B=01, stall=0.
REQ-027 Producer r5, two unrelated NOPs, then consumer reading r5 as RS1 -> mux_sel_A=11; with one NOP between -> 10.
REQ-028 LOAD r6, then ALU_R reading r6 -> stall=1 one cycle with selects 00, next cycle selects 10, RW_dm=6.
REQ-029 r7 written in EX, DM and WB simultaneously, consumer reads r7 -> select 01 (EX priority); consumer reading r0 -> 00.
REQ-030 ALU_I r2<-r2 after ALU_R r2 -> mux_sel_A=01, mux_sel_B=00, imm_sel=1.
REQ-031 Assert rst during a load-use stall -> stall=0, RW_dm=0, wb_we=0 immediately; pipe empty after release.
